// File: rtl/risc_v_defines_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, PC increment and fetch FSM encoding.
package risc_v_defines_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned PC_INC   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC while IF/ID is stalled.
module if_skid_buf
   import risc_v_defines_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr,
   input  logic [INST_WIDTH-1:0] in_inst,
   input  logic [PC_WIDTH-1:0]   in_pc,
   output logic                  full,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [PC_WIDTH-1:0]   out_pc
);

   logic                  full_q, full_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;

   always_comb begin
      full_d = full_q;
      inst_d = inst_q;
      pc_d   = pc_q;
      if (clr || pop) begin
         full_d = 1'b0;
      end else if (push) begin
         full_d = 1'b1;
         inst_d = in_inst;
         pc_d   = in_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         inst_q <= '0;
         pc_q   <= '0;
      end else begin
         full_q <= full_d;
         inst_q <= inst_d;
         pc_q   <= pc_d;
      end
   end

   assign full     = full_q;
   assign out_inst = inst_q;
   assign out_pc   = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, skid buffer and IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module if_fetch_stage
   import risc_v_defines_pkg::*;
#(
   parameter int unsigned         PC_WIDTH   = 32,
   parameter int unsigned         INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_write,
   input  logic                  IF_ID_write,
   input  logic                  IF_ID_flush,
   input  logic                  branch_taken,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_rvalid,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic [PC_WIDTH-1:0]   IF_ID_pc,
   output logic [INST_WIDTH-1:0] IF_ID_inst,
   output logic                  IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

   fetch_state_e          state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d, req_pc_q, req_pc_d;
   logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
   logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
   logic                  id_valid_q, id_valid_d;
   logic                  rsp_live, id_load_valid;
   logic                  skid_push, skid_pop, skid_clr, skid_full;
   logic [INST_WIDTH-1:0] skid_inst;
   logic [PC_WIDTH-1:0]   skid_pc;

   // Only a response to our own WAIT request is live; stray ones after reset are ignored.
   assign rsp_live = (state_q == WAIT) && imem_rvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (imem_req) state_d = WAIT;
         WAIT:    if (imem_rvalid) state_d = IDLE;
                  else if (branch_taken) state_d = DISCARD;
         DISCARD: if (imem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = rst_n && (state_q == IDLE) && pc_write && !skid_full && !branch_taken;
      imem_addr = pc_q;
   end

   always_comb begin
      pc_d          = pc_q;
      req_pc_d      = imem_req ? pc_q : req_pc_q;
      id_pc_d       = id_pc_q;
      id_inst_d     = id_inst_q;
      id_valid_d    = id_valid_q;
      skid_push     = 1'b0;
      skid_pop      = 1'b0;
      skid_clr      = 1'b0;
      id_load_valid = 1'b0;
      if (branch_taken) begin
         pc_d       = branch_target & ~PC_WIDTH'(3);
         id_pc_d    = '0;
         id_inst_d  = NOP;
         id_valid_d = 1'b0;
         skid_clr   = 1'b1;
      end else begin
         if (imem_req) pc_d = pc_q + PC_WIDTH'(PC_INC);
         if (IF_ID_write) begin
            id_pc_d    = '0;
            id_inst_d  = NOP;
            id_valid_d = 1'b0;
            if (IF_ID_flush) begin
               skid_clr = 1'b1;
            end else if (skid_full) begin
               id_pc_d       = skid_pc;
               id_inst_d     = skid_inst;
               id_valid_d    = 1'b1;
               skid_pop      = 1'b1;
               id_load_valid = 1'b1;
            end else if (rsp_live) begin
               id_pc_d       = req_pc_q;
               id_inst_d     = imem_rdata;
               id_valid_d    = 1'b1;
               id_load_valid = 1'b1;
            end
         end else if (rsp_live) begin
            skid_push = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         id_pc_q    <= '0;
         id_inst_q  <= NOP;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign IF_ID_pc    = id_pc_q;
   assign IF_ID_inst  = id_inst_q;
   assign IF_ID_valid = id_valid_q;

   if_skid_buf #(
      .PC_WIDTH   (PC_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (skid_push),
      .pop      (skid_pop),
      .clr      (skid_clr),
      .in_inst  (imem_rdata),
      .in_pc    (req_pc_q),
      .full     (skid_full),
      .out_inst (skid_inst),
      .out_pc   (skid_pc)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + (id_load_valid ? 32'd1 : 32'd0);
      stall_cnt_d = stall_cnt_q + (IF_ID_write ? 32'd0 : 32'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage, plus a wrap-around instance at RESET_PC=0xFFFF_FFFC.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        pcw, wr, fl, br;
      logic [31:0] tgt;
      logic        rv;
      logic [31:0] rd;
      logic        ereq;
      logic [31:0] eaddr;
      logic [31:0] epc, einst;
      logic        evld;
      logic        ewchk;
      logic [31:0] ewval;
   } row_t;

   logic        clk, rst_n;
   logic        pc_write, IF_ID_write, IF_ID_flush, branch_taken;
   logic [31:0] branch_target;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_req, w_req;
   logic [31:0] imem_addr, w_addr;
   logic [31:0] IF_ID_pc, IF_ID_inst, w_pc, w_inst;
   logic        IF_ID_valid, w_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_f, perf_s, w_pf, w_ps;
`endif

   int total = 0;
   int bad   = 0;
   row_t tbl[21];

   if_fetch_stage #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
      .IF_ID_valid(IF_ID_valid)
`ifdef IF_PERF_CNT_EN
     ,.perf_fetch_cnt(perf_f), .perf_stall_cnt(perf_s)
`endif
   );

   if_fetch_stage #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .IF_ID_pc(w_pc), .IF_ID_inst(w_inst),
      .IF_ID_valid(w_valid)
`ifdef IF_PERF_CNT_EN
     ,.perf_fetch_cnt(w_pf), .perf_stall_cnt(w_ps)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic row_t R(input logic pcw, wr, fl, br, input logic [31:0] tgt,
                              input logic rv, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic [31:0] epc, einst, input logic evld);
      row_t r;
      r.pcw = pcw; r.wr = wr; r.fl = fl; r.br = br; r.tgt = tgt;
      r.rv = rv; r.rd = rd; r.ereq = ereq; r.eaddr = eaddr;
      r.epc = epc; r.einst = einst; r.evld = evld;
      r.ewchk = 1'b0; r.ewval = '0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input row_t r);
      pc_write = r.pcw; IF_ID_write = r.wr; IF_ID_flush = r.fl;
      branch_taken = r.br; branch_target = r.tgt;
      imem_rvalid = r.rv; imem_rdata = r.rd;
   endtask

   // Called at posedge+1: drive, check combinational request at negedge, check IF/ID after the edge.
   task automatic apply(input row_t r, input string tag);
      set_in(r);
      #4;
      chk({tag, " imem_req"}, 32'(imem_req), 32'(r.ereq));
      if (r.ereq) chk({tag, " imem_addr"}, imem_addr, r.eaddr);
      if (r.ewchk && r.ereq) begin
         chk({tag, " wrap imem_req"}, 32'(w_req), 32'(1'b1));
         chk({tag, " wrap imem_addr"}, w_addr, r.ewval);
      end
      @(posedge clk); #1;
      if (r.evld) chk({tag, " IF_ID_pc"}, IF_ID_pc, r.epc);
      chk({tag, " IF_ID_inst"}, IF_ID_inst, r.einst);
      chk({tag, " IF_ID_valid"}, 32'(IF_ID_valid), 32'(r.evld));
      if (r.ewchk) begin
         chk({tag, " wrap IF_ID_valid"}, 32'(w_valid), 32'(r.evld));
         chk({tag, " wrap IF_ID_inst"}, w_inst, r.einst);
         if (r.evld) chk({tag, " wrap IF_ID_pc"}, w_pc, r.ewval);
      end
   endtask

   task automatic drive(input row_t r);
      set_in(r);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      set_in(R(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NOP, 0));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset imem_req", 32'(imem_req), 32'd0);
      chk("reset IF_ID_pc", IF_ID_pc, 32'd0);
      chk("reset IF_ID_inst", IF_ID_inst, NOP);
      chk("reset IF_ID_valid", 32'(IF_ID_valid), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h0,   32'h0,   NOP,           0);
      tbl[1]  = R(1,1,0,0, 32'h0,   1, 32'hA000_0000, 0, 32'h0,   32'h0,   32'hA000_0000, 1);
      tbl[2]  = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h4,   32'h0,   NOP,           0);
      tbl[3]  = R(1,1,0,0, 32'h0,   1, 32'hA000_0004, 0, 32'h0,   32'h4,   32'hA000_0004, 1);
      tbl[4]  = R(0,0,1,0, 32'h0,   0, 32'h0,         0, 32'h0,   32'h4,   32'hA000_0004, 1);
      tbl[5]  = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h8,   32'h0,   NOP,           0);
      tbl[6]  = R(0,0,1,0, 32'h0,   1, 32'hA000_0008, 0, 32'h0,   32'h0,   NOP,           0);
      tbl[7]  = R(1,1,0,0, 32'h0,   0, 32'h0,         0, 32'h0,   32'h8,   32'hA000_0008, 1);
      tbl[8]  = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'hC,   32'h0,   NOP,           0);
      tbl[9]  = R(1,1,0,0, 32'h0,   1, 32'hA000_000C, 0, 32'h0,   32'hC,   32'hA000_000C, 1);
      tbl[10] = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h10,  32'h0,   NOP,           0);
      tbl[11] = R(1,1,0,1, 32'h100, 0, 32'h0,         0, 32'h0,   32'h0,   NOP,           0);
      tbl[12] = R(1,1,0,0, 32'h0,   0, 32'h0,         0, 32'h0,   32'h0,   NOP,           0);
      tbl[13] = R(1,1,0,0, 32'h0,   1, 32'hDEAD_BEEF, 0, 32'h0,   32'h0,   NOP,           0);
      tbl[14] = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h100, 32'h0,   NOP,           0);
      tbl[15] = R(1,1,0,0, 32'h0,   1, 32'hA000_0100, 0, 32'h0,   32'h100, 32'hA000_0100, 1);
      tbl[16] = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h104, 32'h0,   NOP,           0);
      tbl[17] = R(1,0,0,1, 32'h103, 1, 32'hBADB_AD00, 0, 32'h0,   32'h0,   NOP,           0);
      tbl[18] = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h100, 32'h0,   NOP,           0);
      tbl[19] = R(1,1,0,0, 32'h0,   1, 32'hA000_0100, 0, 32'h0,   32'h100, 32'hA000_0100, 1);
      tbl[20] = R(1,1,0,0, 32'h0,   0, 32'h0,         1, 32'h104, 32'h0,   NOP,           0);
      // Wrap instance runs in lockstep for the first four rows.
      tbl[0].ewchk = 1'b1; tbl[0].ewval = 32'hFFFF_FFFC;
      tbl[1].ewchk = 1'b1; tbl[1].ewval = 32'hFFFF_FFFC;
      tbl[2].ewchk = 1'b1; tbl[2].ewval = 32'h0000_0000;
      tbl[3].ewchk = 1'b1; tbl[3].ewval = 32'h0000_0000;

      do_reset();
      for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("row%0d", i));

      // Reset cuts off the outstanding 0x104 request; its late response must be ignored.
      rst_n = 1'b0;
      #2;
      chk("midreset imem_req", 32'(imem_req), 32'd0);
      chk("midreset IF_ID_valid", 32'(IF_ID_valid), 32'd0);
      chk("midreset IF_ID_inst", IF_ID_inst, NOP);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(R(1,1,0,0, 32'h0, 1, 32'h0000_0BAD, 1, 32'h0, 32'h0, NOP, 0), "stale0");
      apply(R(1,1,0,0, 32'h0, 1, 32'hA000_0000, 0, 32'h0, 32'h0, 32'hA000_0000, 1), "stale1");

`ifdef IF_PERF_CNT_EN
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i < 3) drive(R(0,0,0,0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, NOP, 0));
         drive(R(1,1,0,0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, NOP, 0));
         drive(R(1,1,0,0, 32'h0, 1, 32'hC000_0000 + 32'(i), 0, 32'h0, 32'h0, NOP, 0));
      end
      chk("perf_fetch_cnt", perf_f, 32'd10);
      chk("perf_stall_cnt", perf_s, 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
